// File: rtl/multi_timeout_check_if.sv
// Bus interface for multi_timeout_check: per-channel strobes, delays and status.
// TIMEOUT_STICKY_EN adds sticky_clr / expired_sticky.
interface multi_timeout_check_if #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned BIT_WIDTH = 16
);
  logic [N_CH-1:0]           restart;
  logic [N_CH-1:0]           cancel;
  logic [N_CH-1:0]           retrig_en;
  logic [N_CH*BIT_WIDTH-1:0] delay_length;
  logic [N_CH-1:0]           active;
  logic [N_CH-1:0]           expired;
  logic                      any_active;
`ifdef TIMEOUT_STICKY_EN
  logic [N_CH-1:0]           sticky_clr;
  logic [N_CH-1:0]           expired_sticky;
`endif

  modport master (
`ifdef TIMEOUT_STICKY_EN
    output sticky_clr,
    input  expired_sticky,
`endif
    output restart, cancel, retrig_en, delay_length,
    input  active, expired, any_active
  );

  modport slave (
`ifdef TIMEOUT_STICKY_EN
    input  sticky_clr,
    output expired_sticky,
`endif
    input  restart, cancel, retrig_en, delay_length,
    output active, expired, any_active
  );
endinterface

// File: rtl/multi_timeout_check.sv
// Multi-channel watchdog: per-channel activity windows with expiry pulses.
// Optional TIMEOUT_STICKY_EN adds a sticky expiry flag per channel.
module multi_timeout_check #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned BIT_WIDTH = 16
) (
  input logic                 clk,
  input logic                 reset,
  multi_timeout_check_if.slave bus
);
  typedef enum logic {ST_IDLE = 1'b0, ST_COUNT = 1'b1} state_e;

  state_e               state_q [N_CH];
  state_e               state_d [N_CH];
  logic [BIT_WIDTH-1:0] cnt_q   [N_CH];
  logic [BIT_WIDTH-1:0] cnt_d   [N_CH];
  logic [N_CH-1:0]      active_q, active_d;
  logic [N_CH-1:0]      expired_q, expired_d;
  logic                 any_active_q, any_active_d;
`ifdef TIMEOUT_STICKY_EN
  logic [N_CH-1:0]      sticky_q, sticky_d;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      active_q     <= '0;
      expired_q    <= '0;
      any_active_q <= 1'b0;
`ifdef TIMEOUT_STICKY_EN
      sticky_q     <= '0;
`endif
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      active_q     <= active_d;
      expired_q    <= expired_d;
      any_active_q <= any_active_d;
`ifdef TIMEOUT_STICKY_EN
      sticky_q     <= sticky_d;
`endif
    end
  end

  // Next state: cancel > retrigger reload > expiry > decrement
  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (bus.restart[i] && !bus.cancel[i]) begin
            state_d[i] = ST_COUNT;
            cnt_d[i]   = bus.delay_length[i*BIT_WIDTH +: BIT_WIDTH];
          end else begin
            cnt_d[i]   = '0;
          end
        end
        ST_COUNT: begin
          if (bus.cancel[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else if (bus.restart[i] && bus.retrig_en[i]) begin
            cnt_d[i]   = bus.delay_length[i*BIT_WIDTH +: BIT_WIDTH];
          end else if (cnt_q[i] == '0) begin
            state_d[i] = ST_IDLE;
          end else begin
            cnt_d[i]   = cnt_q[i] - BIT_WIDTH'(1);
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Outputs derived from the transition; COUNT->IDLE without cancel is a natural expiry
  always_comb begin
    active_d  = '0;
    expired_d = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      active_d[i]  = (state_d[i] == ST_COUNT);
      expired_d[i] = (state_q[i] == ST_COUNT) && (state_d[i] == ST_IDLE) && !bus.cancel[i];
    end
    any_active_d = |active_d;
`ifdef TIMEOUT_STICKY_EN
    sticky_d = (sticky_q & ~bus.sticky_clr) | expired_d;
`endif
  end

  assign bus.active     = active_q;
  assign bus.expired    = expired_q;
  assign bus.any_active = any_active_q;
`ifdef TIMEOUT_STICKY_EN
  assign bus.expired_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_multi_timeout_check.sv
// Testbench for multi_timeout_check: directed scenarios plus random traffic
// against a deadline-based window model. Honors TIMEOUT_STICKY_EN.
module tb_multi_timeout_check;
  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_timeout_check_if #(.N_CH(N), .BIT_WIDTH(W)) tb_if ();
  multi_timeout_check #(.N_CH(N), .BIT_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tb_if.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int t     = 0;

  // Reference model: each open window has an absolute closing edge number
  bit       m_open [N];
  int       m_dead [N];
  bit [N-1:0] m_exp;
  bit [N-1:0] m_sticky;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, t, got, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [N-1:0] rs, input logic [N-1:0] cn,
                            input logic [N-1:0] rt, input logic [N*W-1:0] dl,
                            input logic [N-1:0] clr);
    m_exp = '0;
    for (int i = 0; i < int'(N); i++) begin
      int d;
      d = int'(dl[i*W +: W]);
      if (rst) begin
        m_open[i] = 1'b0;
      end else if (cn[i]) begin
        m_open[i] = 1'b0;
      end else if (!m_open[i]) begin
        if (rs[i]) begin
          m_open[i] = 1'b1;
          m_dead[i] = t + d + 1;
        end
      end else if (rs[i] && rt[i]) begin
        m_dead[i] = t + d + 1;
      end else if (t == m_dead[i]) begin
        m_open[i] = 1'b0;
        m_exp[i]  = 1'b1;
      end
    end
    if (rst) m_sticky = '0;
    else     m_sticky = (m_sticky & ~N'(clr)) | m_exp;
  endtask

  task automatic step(input logic rst, input logic [N-1:0] rs, input logic [N-1:0] cn,
                      input logic [N-1:0] rt, input logic [N*W-1:0] dl,
                      input logic [N-1:0] clr);
    bit [N-1:0] exp_act;
    @(negedge clk);
    reset              = rst;
    tb_if.restart      = rs;
    tb_if.cancel       = cn;
    tb_if.retrig_en    = rt;
    tb_if.delay_length = dl;
`ifdef TIMEOUT_STICKY_EN
    tb_if.sticky_clr   = clr;
`endif
    @(posedge clk);
    t++;
    model_edge(rst, rs, cn, rt, dl, clr);
    #1;
    for (int i = 0; i < int'(N); i++) exp_act[i] = m_open[i];
    check("active",     32'(tb_if.active),     32'(exp_act));
    check("expired",    32'(tb_if.expired),    32'(m_exp));
    check("any_active", 32'(tb_if.any_active), 32'(|exp_act));
`ifdef TIMEOUT_STICKY_EN
    check("expired_sticky", 32'(tb_if.expired_sticky), 32'(m_sticky));
`endif
  endtask

  initial begin
    logic [N*W-1:0] dl;
    logic [N-1:0]   rs, cn, clr;
    for (int i = 0; i < int'(N); i++) begin
      m_open[i] = 1'b0;
      m_dead[i] = 0;
    end
    m_exp = '0;
    m_sticky = '0;
    reset = 1'b1;
    tb_if.restart = '0;
    tb_if.cancel = '0;
    tb_if.retrig_en = '0;
    tb_if.delay_length = '0;
`ifdef TIMEOUT_STICKY_EN
    tb_if.sticky_clr = '0;
`endif

    // Reset state, with literal expectations
    step(1'b1, '0, '0, '0, '0, '0);
    step(1'b1, '0, '0, '0, '0, '0);
    check("rst_active", 32'(tb_if.active), 32'd0);
    check("rst_any",    32'(tb_if.any_active), 32'd0);

    // Test-plan scenarios: ch0 D5 retrig, ch1 D8 retrig, ch2 D8 one-shot, ch3 D20 cancel
    dl = {16'd20, 16'd8, 16'd8, 16'd5};
    for (int c = 0; c < 40; c++) begin
      rs = '0;
      cn = '0;
      if (c == 10) rs = 4'b1111;
      if (c == 15) rs = 4'b0110;
      if (c == 14) cn = 4'b1000;
      if (c == 30) begin
        rs = 4'b1000;
        cn = 4'b1000;
      end
      clr = (c == 17) ? 4'b0001 : 4'b0000;
      step(1'b0, rs, cn, 4'b1011, dl, clr);
    end
    step(1'b0, '0, '0, '0, '0, 4'b0001);

    // Reset mid-count, then D=0 windows back to back
    dl = {16'd3, 16'd3, 16'd3, 16'd3};
    step(1'b0, 4'b1111, '0, 4'b1111, dl, '0);
    step(1'b0, '0, '0, 4'b1111, dl, '0);
    step(1'b1, '0, '0, 4'b1111, dl, '0);
    check("midrst_expired", 32'(tb_if.expired), 32'd0);
    for (int c = 0; c < 6; c++)
      step(1'b0, (c == 0 || c == 2) ? 4'b1111 : 4'b0000, '0, 4'b1111, '0, '0);

    // Randomized traffic; small delays exercise expiry/reload collisions
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        dl[i*W +: W] = W'($urandom_range(0, 9));
        rs[i]  = ($urandom_range(0, 5) == 0);
        cn[i]  = ($urandom_range(0, 19) == 0);
        clr[i] = ($urandom_range(0, 3) == 0);
      end
      step(($urandom_range(0, 249) == 0), rs, cn, N'($urandom), dl, clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
